uart_tx_feeder: RTL and testbench

Byte-buffering front end for the UART transmit path. Host logic pushes bytes into an internal FIFO at clock rate. The block drains the FIFO one byte at a time into the transmitter's `tx_start` / `tx_data` / `busy` interface, so the host never has to track serial timing. It sits directly upstream of the UART top level and shares its clock and reset.

---
 rtl/uart_tx_feeder.sv | 145 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter. Queued bytes are handed over one at a time
// through the tx_start/tx_data/busy handshake, with a bounded wait for busy to rise.
module uart_tx_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned REQ_TIMEOUT = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              req_timeout,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              busy
);

    localparam int unsigned     TmoW     = $clog2(REQ_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(REQ_TIMEOUT - 1);
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitDone
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              req_timeout_q, req_timeout_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    state_e            state_q, state_d;
    logic              push;
    logic              pop;

    assign full        = (count_q == DepthCnt);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign req_timeout = req_timeout_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

    // Acceptance uses the registered full flag, so a same-cycle pop never frees a slot early.
    assign push       = wr_en & ~full;
    assign overflow_d = wr_en & full;

    always_comb begin
        state_d       = state_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        tmo_d         = tmo_q;
        req_timeout_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && !busy) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (busy) begin
                    tx_start_d = 1'b0;
                    state_d    = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    // Transmitter never acknowledged: drop the byte rather than stall the queue.
                    tx_start_d    = 1'b0;
                    req_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitDone: begin
                if (!busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            req_timeout_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            req_timeout_q <= req_timeout_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            tmo_q         <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: single byte, burst, overflow, timeout, reset, wrap.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       req_timeout;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;

    logic       man_busy;
    logic       auto_busy;
    logic       model_busy = 1'b0;
    int         busy_len;
    int         bcnt = 0;
    int         cyc = 0;
    int         last_fall = 0;
    int         ovf_cnt = 0;
    logic [7:0] recv_q[$];
    int         gap_q[$];

    int checks = 0;
    int failures = 0;

    uart_tx_feeder #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .REQ_TIMEOUT (8192)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .req_timeout (req_timeout),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign busy = auto_busy ? model_busy : man_busy;

    // Transmitter model: takes each request, holds busy for busy_len clocks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (overflow) ovf_cnt++;
            if (!auto_busy) begin
                model_busy = 1'b0;
                bcnt = 0;
            end else if (model_busy) begin
                bcnt--;
                if (bcnt == 0) begin
                    model_busy = 1'b0;
                    last_fall = cyc;
                end
            end else if (tx_start) begin
                recv_q.push_back(tx_data);
                gap_q.push_back(cyc - last_fall);
                model_busy = 1'b1;
                bcnt = busy_len;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input int n);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (recv_q.size() >= n && !busy && empty && !tx_start) break;
            step(1);
        end
        check("drain_done", 32'(k < 3000), 1);
        step(3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_req_timeout"}, 32'(req_timeout), 0);
    endtask

    initial begin
        int base;
        int ovf0;
        int peak;
        int hi;
        int early;
        int spurious;

        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        man_busy = 1'b0;
        auto_busy = 1'b0;
        busy_len = 20;
        step(2);
        check_reset_vals("reset");
        rst = 1'b0;

        // Single byte
        wr_en = 1'b1;
        wr_data = 8'hA5;
        step(1);
        wr_en = 1'b0;
        check("single_count1", 32'(count), 1);
        check("single_empty0", 32'(empty), 0);
        check("single_nostart_yet", 32'(tx_start), 0);
        step(1);
        check("single_start", 32'(tx_start), 1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_popped", 32'(empty), 1);
        step(2);
        check("single_hold_start", 32'(tx_start), 1);
        check("single_hold_data", 32'(tx_data), 32'hA5);
        man_busy = 1'b1;
        step(1);
        check("single_start_clr", 32'(tx_start), 0);
        man_busy = 1'b0;
        step(3);
        check("single_idle_start", 32'(tx_start), 0);
        check("single_idle_empty", 32'(empty), 1);

        // Burst of 16 with 20-clock busy per byte
        base = recv_q.size();
        ovf0 = ovf_cnt;
        peak = 0;
        busy_len = 20;
        auto_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i + 1);
            step(1);
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        check("burst_peak", 32'(peak), 15);
        wait_drain(base + 16);
        check("burst_size", 32'(recv_q.size() - base), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("burst_byte%0d", i), 32'(recv_q[base + i]), 32'(i + 1));
            if (i > 0) check($sformatf("burst_gap%0d", i), 32'(gap_q[base + i]), 2);
        end
        check("burst_no_ovf", 32'(ovf_cnt - ovf0), 0);

        // Overflow with transmitter held busy
        auto_busy = 1'b0;
        man_busy = 1'b1;
        step(1);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
            step(1);
            if (i == 15) begin
                check("ovf_full16", 32'(full), 1);
                check("ovf_count16", 32'(count), 16);
                check("ovf_not_yet", 32'(overflow), 0);
            end
        end
        wr_en = 1'b0;
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count17", 32'(count), 16);
        check("ovf_blocked_start", 32'(tx_start), 0);
        step(1);
        check("ovf_pulse_end", 32'(overflow), 0);
        base = recv_q.size();
        busy_len = 3;
        auto_busy = 1'b1;
        man_busy = 1'b0;
        wait_drain(base + 16);
        step(10);
        check("ovf_sent16", 32'(recv_q.size() - base), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_byte%0d", i), 32'(recv_q[base + i]), 32'(8'h40 + i));
        end

        // Request timeout
        auto_busy = 1'b0;
        man_busy = 1'b0;
        step(2);
        wr_en = 1'b1;
        wr_data = 8'h3C;
        step(1);
        wr_en = 1'b0;
        step(1);
        check("tmo_start", 32'(tx_start), 1);
        check("tmo_data", 32'(tx_data), 32'h3C);
        hi = 1;
        early = 0;
        for (int k = 0; k < 9000; k++) begin
            step(1);
            if (!tx_start) break;
            hi++;
            if (req_timeout) early++;
        end
        check("tmo_high_clocks", 32'(hi), 8192);
        check("tmo_no_early_pulse", 32'(early), 0);
        check("tmo_pulse", 32'(req_timeout), 1);
        check("tmo_empty", 32'(empty), 1);
        step(1);
        check("tmo_pulse_end", 32'(req_timeout), 0);
        check("tmo_stays_idle", 32'(tx_start), 0);

        // Reset while waiting for the transmitter to finish
        wr_en = 1'b1;
        wr_data = 8'h61;
        step(1);
        wr_data = 8'h62;
        step(1);
        check("rst_pre_start", 32'(tx_start), 1);
        check("rst_pre_data", 32'(tx_data), 32'h61);
        man_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h63 + i);
            step(1);
        end
        wr_en = 1'b0;
        check("rst_pre_count", 32'(count), 5);
        check("rst_pre_waiting", 32'(tx_start), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_vals("midrst");
        step(1);
        man_busy = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (tx_start) spurious++;
        end
        check("midrst_no_start", 32'(spurious), 0);
        check("midrst_count", 32'(count), 0);

        // Stream 40 bytes through a fast transmitter so both pointers wrap
        base = recv_q.size();
        ovf0 = ovf_cnt;
        busy_len = 1;
        auto_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h80 + i);
            step(1);
            wr_en = 1'b0;
            step(3);
        end
        wait_drain(base + 40);
        check("wrap_size", 32'(recv_q.size() - base), 40);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("wrap_byte%0d", i), 32'(recv_q[base + i]), 32'(8'h80 + i));
        end
        check("wrap_no_ovf", 32'(ovf_cnt - ovf0), 0);
        check("wrap_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
